// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg
//   Shared defaults for the edge event arbiter: default line count and the
//   event id width derived from it.
package edge_arb_pkg;

    localparam int DEFAULT_N_INPUTS = 4;

    // Width of an index into n lines. A single line still needs one id bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_edge_pulse_cell.sv
// edge_pulse_cell
//   Rising-edge detector for one monitored line.
//   Ports:
//     clock  - rising-edge clock
//     reset  - asynchronous active-high reset, clears the previous sample
//     in     - monitored line, synchronous to clock
//     pulse  - high for the single cycle in which in=1 and the previous
//              sample was 0
module edge_pulse_cell (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev_reg;

    // Previous sample clears to 0, so a line held high through reset release
    // is reported as one rising edge on the first clock after release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= in;
        end
    end

    assign pulse = in & ~prev_reg;

endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Watches N_INPUTS lines for rising edges, queues one pending event per
//   line and presents them one at a time through a valid/ready output stage,
//   choosing among pending lines in round-robin order.
//   Ports:
//     clock         - rising-edge clock
//     reset         - asynchronous active-high reset
//     in            - monitored lines
//     event_valid   - an event is presented
//     event_id      - index of the line whose edge is presented
//     event_ready   - consumer accepts the presented event
//     overrun       - sticky per-line flags for dropped edges
//     clear_overrun - clears all overrun flags
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_INPUTS = DEFAULT_N_INPUTS,
    parameter int ID_W     = id_width(N_INPUTS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] in,
    output logic                event_valid,
    output logic [ID_W-1:0]     event_id,
    input  logic                event_ready,
    output logic [N_INPUTS-1:0] overrun,
    input  logic                clear_overrun
);

    logic [N_INPUTS-1:0] edge_pulse;
    logic [N_INPUTS-1:0] pending_reg;
    logic [N_INPUTS-1:0] pending_next;
    logic [N_INPUTS-1:0] overrun_reg;
    logic [N_INPUTS-1:0] overrun_next;
    logic [N_INPUTS-1:0] overrun_set;
    logic [N_INPUTS-1:0] clear_mask;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     ptr_next;
    logic [ID_W-1:0]     winner_id;
    logic                winner_found;
    logic                valid_reg;
    logic [ID_W-1:0]     id_reg;
    logic                stage_empty;
    logic                any_pending;
    logic                load;
    int                  scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_edge
            edge_pulse_cell u_cell (
                .clock (clock),
                .reset (reset),
                .in    (in[gi]),
                .pulse (edge_pulse[gi])
            );
        end
    endgenerate

    assign stage_empty = ~valid_reg | event_ready;
    assign any_pending = |pending_reg;
    assign load        = stage_empty & any_pending;

    // Round-robin scan: first pending line at ptr, ptr+1, ... wrapping.
    always_comb begin
        winner_id    = '0;
        winner_found = 1'b0;
        scan_idx     = 0;
        for (int off = 0; off < N_INPUTS; off++) begin
            scan_idx = (int'(ptr_reg) + off) % N_INPUTS;
            if (!winner_found && pending_reg[scan_idx]) begin
                winner_found = 1'b1;
                winner_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        clear_mask = '0;
        if (load) begin
            clear_mask[winner_id] = 1'b1;
        end
    end

    // A line whose pending bit is being consumed this cycle may take a new
    // edge without loss; only an edge on a still-pending line is dropped.
    assign overrun_set  = edge_pulse & pending_reg & ~clear_mask;
    assign pending_next = (pending_reg & ~clear_mask) | edge_pulse;
    // The set term is ORed last so an overrun wins over a simultaneous clear.
    assign overrun_next = (clear_overrun ? '0 : overrun_reg) | overrun_set;

    always_comb begin
        ptr_next = ptr_reg;
        if (load) begin
            if (int'(winner_id) == N_INPUTS - 1) begin
                ptr_next = '0;
            end else begin
                ptr_next = winner_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
            overrun_reg <= '0;
            ptr_reg     <= '0;
            valid_reg   <= 1'b0;
            id_reg      <= '0;
        end else begin
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            ptr_reg     <= ptr_next;
            // Output stage holds its contents under backpressure.
            if (stage_empty) begin
                valid_reg <= any_pending;
                if (any_pending) begin
                    id_reg <= winner_id;
                end
            end
        end
    end

    assign event_valid = valid_reg;
    assign event_id    = id_reg;
    assign overrun     = overrun_reg;

endmodule
